// File: rtl/vector_checker_pkg.sv
// vector_checker_pkg
// Shared types and helpers for the vector checker:
//   state_t      - sequencer state encoding
//   addr_w/vec_w - derived address and vector-word widths
//   word_*       - field extraction from a vector word
// Macro VECTOR_CHECKER_XMASK_EN adds a per-bit care field to each word,
// giving the layout {in, exp, care}; without it the layout is {in, exp}.
// Field functions work on a zero-extended MAX_W-bit word. The caller
// size-casts the result down to the field width.

package vector_checker_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_APPLY  = 2'd1,
        S_SAMPLE = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam int MAX_W = 64;
    typedef logic [MAX_W-1:0] word_t;

    function automatic int addr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    function automatic int vec_w(input int in_w, input int out_w);
`ifdef VECTOR_CHECKER_XMASK_EN
        return in_w + 2 * out_w;
`else
        return in_w + out_w;
`endif
    endfunction

    // Stimulus field, shifted down to bit 0.
    function automatic word_t word_in(input word_t w, input int out_w);
`ifdef VECTOR_CHECKER_XMASK_EN
        return w >> (2 * out_w);
`else
        return w >> out_w;
`endif
    endfunction

    // Expected-response field, shifted down to bit 0.
    function automatic word_t word_exp(input word_t w, input int out_w);
`ifdef VECTOR_CHECKER_XMASK_EN
        return w >> out_w;
`else
        return w;
`endif
    endfunction

`ifdef VECTOR_CHECKER_XMASK_EN
    // The care field is already in the low bits.
    function automatic word_t word_care(input word_t w);
        return w;
    endfunction
`endif

endpackage

// File: rtl/vector_checker_mem.sv
// vector_checker_mem
// DEPTH x VEC_W vector storage. It has a synchronous write port and an
// asynchronous read port. It has no reset, so the contents survive a
// checker reset.
// Ports:
//   clk      - write clock
//   i_we     - write enable
//   i_waddr  - write address
//   i_wdata  - write data
//   i_raddr  - read address
//   o_rdata  - read data (combinational)

module vector_checker_mem #(
    parameter int DEPTH  = 32,
    parameter int ADDR_W = 5,
    parameter int VEC_W  = 3
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [ADDR_W-1:0] i_waddr,
    input  logic [VEC_W-1:0]  i_wdata,
    input  logic [ADDR_W-1:0] i_raddr,
    output logic [VEC_W-1:0]  o_rdata
);

    logic [VEC_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/vector_checker.sv
// vector_checker
// Sequences stored stimulus/expected words into a combinational DUT. It
// compares each response and reports the saturating error count and the
// first mismatch.
// Ports:
//   clk, reset(active-low async)
//   load_en/load_addr/load_data  - vector memory write (ignored while busy)
//   start/num_vec/halt_on_err    - run control (start accepted in IDLE/DONE)
//   dut_in (out) / dut_out (in)  - DUT stimulus and response
//   busy, done, pass, err_count, vec_index - run status
//   fail_valid/index/in/exp/got  - first-mismatch capture
// Optional: VECTOR_CHECKER_XMASK_EN enables per-bit don't-care masking.
//
// state  | meaning
// IDLE   | after reset, waiting for start
// APPLY  | register stimulus of vector idx onto dut_in
// SAMPLE | compare dut_out with expected value of vector idx
// DONE   | run finished, results held until next start

module vector_checker
    import vector_checker_pkg::*;
#(
    parameter  int IN_W   = 2,
    parameter  int OUT_W  = 1,
    parameter  int DEPTH  = 32,
    parameter  int CNT_W  = 11,
    localparam int ADDR_W = addr_w(DEPTH),
    localparam int VEC_W  = vec_w(IN_W, OUT_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load_en,
    input  logic [ADDR_W-1:0] load_addr,
    input  logic [VEC_W-1:0]  load_data,
    input  logic              start,
    input  logic [ADDR_W:0]   num_vec,
    input  logic              halt_on_err,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  err_count,
    output logic [ADDR_W-1:0] vec_index,
    output logic              fail_valid,
    output logic [ADDR_W-1:0] fail_index,
    output logic [IN_W-1:0]   fail_in,
    output logic [OUT_W-1:0]  fail_exp,
    output logic [OUT_W-1:0]  fail_got
);

    state_t            r_state;
    state_t            w_state_nx;
    logic [ADDR_W-1:0] r_idx;
    logic [ADDR_W-1:0] r_last;
    logic              r_halt;
    logic [IN_W-1:0]   r_dut_in;
    logic [CNT_W-1:0]  r_err;
    logic              r_fail_valid;
    logic [ADDR_W-1:0] r_fail_index;
    logic [IN_W-1:0]   r_fail_in;
    logic [OUT_W-1:0]  r_fail_exp;
    logic [OUT_W-1:0]  r_fail_got;

    logic              w_busy;
    logic              w_idle_or_done;
    logic [VEC_W-1:0]  w_rd_data;
    logic [IN_W-1:0]   w_vec_in;
    logic [OUT_W-1:0]  w_vec_exp;
    logic [OUT_W-1:0]  w_care;
    logic              w_mismatch;
    logic              w_sample_exit;
    logic [ADDR_W:0]   w_num_clamped;

    assign w_busy         = (r_state == S_APPLY) || (r_state == S_SAMPLE);
    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);

    vector_checker_mem #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .VEC_W  (VEC_W)
    ) u_mem (
        .clk     (clk),
        .i_we    (load_en && !w_busy),
        .i_waddr (load_addr),
        .i_wdata (load_data),
        .i_raddr (r_idx),
        .o_rdata (w_rd_data)
    );

    assign w_vec_in  = IN_W'(word_in(word_t'(w_rd_data), OUT_W));
    assign w_vec_exp = OUT_W'(word_exp(word_t'(w_rd_data), OUT_W));
`ifdef VECTOR_CHECKER_XMASK_EN
    assign w_care    = OUT_W'(word_care(word_t'(w_rd_data)));
`else
    assign w_care    = '1;
`endif

    assign w_mismatch    = |((dut_out ^ w_vec_exp) & w_care);
    assign w_sample_exit = (r_idx == r_last) || (w_mismatch && r_halt);

    // Requests beyond the memory depth run the whole memory once.
    assign w_num_clamped = (num_vec > (ADDR_W + 1)'(DEPTH)) ?
                           (ADDR_W + 1)'(DEPTH) : num_vec;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    w_state_nx = (num_vec == '0) ? S_DONE : S_APPLY;
                end
            end
            S_APPLY:  w_state_nx = S_SAMPLE;
            S_SAMPLE: w_state_nx = w_sample_exit ? S_DONE : S_APPLY;
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idx        <= '0;
            r_last       <= '0;
            r_halt       <= 1'b0;
            r_dut_in     <= '0;
            r_err        <= '0;
            r_fail_valid <= 1'b0;
            r_fail_index <= '0;
            r_fail_in    <= '0;
            r_fail_exp   <= '0;
            r_fail_got   <= '0;
        end else begin
            if (w_idle_or_done && start) begin
                r_idx        <= '0;
                // A zero count wraps here, but that case goes straight to DONE.
                r_last       <= ADDR_W'(w_num_clamped - 1'b1);
                r_halt       <= halt_on_err;
                r_err        <= '0;
                r_fail_valid <= 1'b0;
                r_fail_index <= '0;
                r_fail_in    <= '0;
                r_fail_exp   <= '0;
                r_fail_got   <= '0;
            end
            if (r_state == S_APPLY) begin
                r_dut_in <= w_vec_in;
            end
            if (r_state == S_SAMPLE) begin
                if (w_mismatch) begin
                    if (r_err != '1) begin
                        r_err <= r_err + 1'b1;
                    end
                    if (!r_fail_valid) begin
                        r_fail_valid <= 1'b1;
                        r_fail_index <= r_idx;
                        r_fail_in    <= r_dut_in;
                        r_fail_exp   <= w_vec_exp;
                        r_fail_got   <= dut_out;
                    end
                end
                if (!w_sample_exit) begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign dut_in     = r_dut_in;
    assign busy       = w_busy;
    assign done       = (r_state == S_DONE);
    assign pass       = (r_state == S_DONE) && (r_err == '0);
    assign err_count  = r_err;
    assign vec_index  = r_idx;
    assign fail_valid = r_fail_valid;
    assign fail_index = r_fail_index;
    assign fail_in    = r_fail_in;
    assign fail_exp   = r_fail_exp;
    assign fail_got   = r_fail_got;

endmodule

// File: tb/tb_vector_checker.sv
// tb_vector_checker
// Directed bench for vector_checker. It drives an XOR DUT with the default
// parameters, plus a second instance with CNT_W = 2 for saturation.
// Honours VECTOR_CHECKER_XMASK_EN in the same way as the design.

`timescale 1ns/1ps

module tb_vector_checker;

`ifdef VECTOR_CHECKER_XMASK_EN
    localparam int VW = 4;
`else
    localparam int VW = 3;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic          load_en;
    logic [4:0]    load_addr;
    logic [VW-1:0] load_data;
    logic          start;
    logic [5:0]    num_vec;
    logic          halt_on_err;

    logic [1:0] dut_in;
    logic       dut_out;
    logic       busy, done, pass;
    logic [10:0] err_count;
    logic [4:0] vec_index;
    logic       fail_valid;
    logic [4:0] fail_index;
    logic [1:0] fail_in;
    logic       fail_exp, fail_got;

    logic [1:0] s_dut_in;
    logic       s_dut_out;
    logic       s_busy, s_done, s_pass;
    logic [1:0] s_err;
    logic [4:0] s_vec_index;
    logic       s_fail_valid;
    logic [4:0] s_fail_index;
    logic [1:0] s_fail_in;
    logic       s_fail_exp, s_fail_got;

    logic [1:0] m_in [32];
    int n_checks = 0;
    int n_errors = 0;
    int cyc;
    bit seq_ok;

    always #5 clk = ~clk;

    assign dut_out   = ^dut_in;
    assign s_dut_out = ^s_dut_in;

    vector_checker u_dut (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .num_vec(num_vec),
        .halt_on_err(halt_on_err), .dut_in(dut_in), .dut_out(dut_out),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count),
        .vec_index(vec_index), .fail_valid(fail_valid), .fail_index(fail_index),
        .fail_in(fail_in), .fail_exp(fail_exp), .fail_got(fail_got)
    );

    vector_checker #(.CNT_W(2)) u_sat (
        .clk(clk), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .start(start), .num_vec(num_vec),
        .halt_on_err(halt_on_err), .dut_in(s_dut_in), .dut_out(s_dut_out),
        .busy(s_busy), .done(s_done), .pass(s_pass), .err_count(s_err),
        .vec_index(s_vec_index), .fail_valid(s_fail_valid),
        .fail_index(s_fail_index), .fail_in(s_fail_in),
        .fail_exp(s_fail_exp), .fail_got(s_fail_got)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input int a, input logic [VW-1:0] w);
        load_en   = 1'b1;
        load_addr = a[4:0];
        load_data = w;
        tick();
        load_en   = 1'b0;
    endtask

    task automatic load_vec(input int a, input logic [1:0] vin, input logic vexp);
        m_in[a] = vin;
`ifdef VECTOR_CHECKER_XMASK_EN
        load_word(a, {vin, vexp, 1'b1});
`else
        load_word(a, {vin, vexp});
`endif
    endtask

    task automatic load_xor(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            load_vec(i, 2'(i % 4), ^(2'(i % 4)));
        end
    endtask

    task automatic do_start(input int n, input logic h);
        num_vec     = n[5:0];
        halt_on_err = h;
        start       = 1'b1;
        tick();
        start       = 1'b0;
    endtask

    // Counts edges after the start edge until done; checks each applied stimulus.
    task automatic wait_done(input int cyc0, input int limit, output int cycles, output bit ok);
        cycles = cyc0;
        ok = 1'b1;
        while (!done && cycles < limit) begin
            tick();
            cycles++;
            if (cycles % 2 == 1) begin
                int i;
                i = (cycles - 1) / 2;
                if (i > 31) ok = 1'b0;
                else if (dut_in !== m_in[i]) ok = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0;
        start = 1'b0; num_vec = '0; halt_on_err = 1'b0;
        tick(); tick();
        n_checks++;
        if ({dut_in, busy, done, pass, err_count, vec_index} !== '0) begin
            n_errors++;
            $display("FAIL reset_status got %0h want 0", {dut_in, busy, done, pass, err_count, vec_index});
        end
        n_checks++;
        if ({fail_valid, fail_index, fail_in, fail_exp, fail_got} !== '0) begin
            n_errors++;
            $display("FAIL reset_fail got %0h want 0", {fail_valid, fail_index, fail_in, fail_exp, fail_got});
        end
        reset = 1'b1;
        tick();
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL idle_after_release busy %0b done %0b want 0 0", busy, done);
        end
    endtask

    task automatic test_clean_run();
        load_xor(0, 23);
        do_start(24, 1'b0);
        n_checks++;
        if (busy !== 1'b1) begin n_errors++; $display("FAIL clean_busy got %0b want 1", busy); end
        wait_done(0, 200, cyc, seq_ok);
        n_checks++;
        if (cyc != 48) begin n_errors++; $display("FAIL clean_cycles got %0d want 48", cyc); end
        n_checks++;
        if (seq_ok !== 1'b1) begin n_errors++; $display("FAIL clean_stimulus got %0b want 1", seq_ok); end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 11'd0 || fail_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL clean_result pass %0b err %0d fv %0b want 1 0 0", pass, err_count, fail_valid);
        end
        n_checks++;
        if (dut_in !== 2'd3) begin n_errors++; $display("FAIL clean_hold_dut_in got %0d want 3", dut_in); end
    endtask

    task automatic test_single_error();
        load_vec(5, 2'b10, 1'b0);
        do_start(24, 1'b0);
        wait_done(0, 200, cyc, seq_ok);
        n_checks++;
        if (err_count !== 11'd1 || pass !== 1'b0) begin
            n_errors++;
            $display("FAIL single_err err %0d pass %0b want 1 0", err_count, pass);
        end
        n_checks++;
        if (fail_valid !== 1'b1 || fail_index !== 5'd5 || fail_in !== 2'b10) begin
            n_errors++;
            $display("FAIL single_capture fv %0b idx %0d in %0d want 1 5 2", fail_valid, fail_index, fail_in);
        end
        n_checks++;
        if (fail_exp !== 1'b0 || fail_got !== 1'b1) begin
            n_errors++;
            $display("FAIL single_exp_got exp %0b got %0b want 0 1", fail_exp, fail_got);
        end
        n_checks++;
        if (cyc != 48 || vec_index !== 5'd23) begin
            n_errors++;
            $display("FAIL single_len cycles %0d idx %0d want 48 23", cyc, vec_index);
        end
    endtask

    task automatic test_halt();
        load_vec(9, 2'b01, 1'b0);
        do_start(24, 1'b1);
        wait_done(0, 200, cyc, seq_ok);
        n_checks++;
        if (cyc != 12) begin n_errors++; $display("FAIL halt_cycles got %0d want 12", cyc); end
        n_checks++;
        if (err_count !== 11'd1 || vec_index !== 5'd5 || fail_index !== 5'd5) begin
            n_errors++;
            $display("FAIL halt_state err %0d idx %0d fidx %0d want 1 5 5", err_count, vec_index, fail_index);
        end
    endtask

    task automatic test_num_vec_bounds();
        load_vec(5, 2'b01, 1'b1);
        load_vec(9, 2'b01, 1'b1);
        load_xor(24, 31);
        do_start(0, 1'b0);
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            n_errors++;
            $display("FAIL zero_vec done %0b pass %0b busy %0b want 1 1 0", done, pass, busy);
        end
        do_start(40, 1'b0);
        wait_done(0, 300, cyc, seq_ok);
        n_checks++;
        if (cyc != 64 || pass !== 1'b1 || seq_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL clamp_run cycles %0d pass %0b seq %0b want 64 1 1", cyc, pass, seq_ok);
        end
        n_checks++;
        if (vec_index !== 5'd31) begin n_errors++; $display("FAIL clamp_last_idx got %0d want 31", vec_index); end
    endtask

    task automatic test_ignored_while_busy();
        do_start(24, 1'b0);
        tick(); tick(); tick();
        start     = 1'b1;
        num_vec   = '0;
        load_en   = 1'b1;
        load_addr = 5'd20;
        load_data = '1;
        tick();
        start   = 1'b0;
        load_en = 1'b0;
        wait_done(4, 200, cyc, seq_ok);
        n_checks++;
        if (cyc != 48 || pass !== 1'b1 || err_count !== 11'd0) begin
            n_errors++;
            $display("FAIL busy_ignore cycles %0d pass %0b err %0d want 48 1 0", cyc, pass, err_count);
        end
    endtask

    task automatic test_reset_midrun();
        load_vec(5, 2'b10, 1'b0);
        do_start(24, 1'b0);
        for (int i = 0; i < 21; i++) tick();
        n_checks++;
        if (dut_in !== 2'd2 || err_count !== 11'd1 || vec_index !== 5'd10) begin
            n_errors++;
            $display("FAIL pre_reset in %0d err %0d idx %0d want 2 1 10", dut_in, err_count, vec_index);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({dut_in, busy, done, pass, err_count, vec_index, fail_valid, fail_index,
             fail_in, fail_exp, fail_got} !== '0) begin
            n_errors++;
            $display("FAIL midrun_reset busy %0b err %0d idx %0d fv %0b want all 0",
                     busy, err_count, vec_index, fail_valid);
        end
        tick();
        reset = 1'b1;
        load_vec(5, 2'b10, 1'b1);
        do_start(24, 1'b0);
        wait_done(0, 200, cyc, seq_ok);
        n_checks++;
        if (cyc != 48 || pass !== 1'b1 || seq_ok !== 1'b1) begin
            n_errors++;
            $display("FAIL rerun cycles %0d pass %0b seq %0b want 48 1 1", cyc, pass, seq_ok);
        end
    endtask

`ifdef VECTOR_CHECKER_XMASK_EN
    task automatic test_mask();
        m_in[5] = 2'b10;
        load_word(5, {2'b10, 1'b0, 1'b0});
        do_start(24, 1'b0);
        wait_done(0, 200, cyc, seq_ok);
        n_checks++;
        if (err_count !== 11'd0 || pass !== 1'b1) begin
            n_errors++;
            $display("FAIL mask_dont_care err %0d pass %0b want 0 1", err_count, pass);
        end
        load_word(5, {2'b10, 1'b0, 1'b1});
        do_start(24, 1'b0);
        wait_done(0, 200, cyc, seq_ok);
        n_checks++;
        if (err_count !== 11'd1 || fail_index !== 5'd5) begin
            n_errors++;
            $display("FAIL mask_care err %0d fidx %0d want 1 5", err_count, fail_index);
        end
    endtask
`endif

    task automatic test_saturation();
        for (int i = 0; i < 24; i++) begin
            load_vec(i, 2'(i % 4), ~(^(2'(i % 4))));
        end
        do_start(24, 1'b0);
        wait_done(0, 200, cyc, seq_ok);
        n_checks++;
        if (err_count !== 11'd24 || fail_index !== 5'd0) begin
            n_errors++;
            $display("FAIL wide_count err %0d fidx %0d want 24 0", err_count, fail_index);
        end
        n_checks++;
        if (s_err !== 2'd3 || s_fail_index !== 5'd0 || s_fail_valid !== 1'b1) begin
            n_errors++;
            $display("FAIL sat_count err %0d fidx %0d fv %0b want 3 0 1", s_err, s_fail_index, s_fail_valid);
        end
        n_checks++;
        if (s_fail_in !== 2'd0 || s_fail_exp !== 1'b1 || s_fail_got !== 1'b0) begin
            n_errors++;
            $display("FAIL sat_capture in %0d exp %0b got %0b want 0 1 0", s_fail_in, s_fail_exp, s_fail_got);
        end
        n_checks++;
        if (s_done !== 1'b1 || s_pass !== 1'b0 || s_busy !== 1'b0 || s_vec_index !== 5'd23) begin
            n_errors++;
            $display("FAIL sat_status done %0b pass %0b busy %0b idx %0d want 1 0 0 23",
                     s_done, s_pass, s_busy, s_vec_index);
        end
    endtask

    initial begin
        test_reset();
        test_clean_run();
        test_single_error();
        test_halt();
        test_num_vec_bounds();
        test_ignored_while_busy();
        test_reset_midrun();
`ifdef VECTOR_CHECKER_XMASK_EN
        test_mask();
`endif
        test_saturation();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
